freq_meter: RTL and testbench

Measures the frequency of an asynchronous square wave and reports it in Hz. It counts synchronized rising edges over a fixed gate window derived from the system clock, then scales the count. It is the receive-side counterpart of the tone generator: tone/audio feedback or external oscillators route through it into the game logic for pitch checking and self-test.

---
 rtl/freq_meter.sv | 137 +++++++++++++
 tb/tb_freq_meter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: measures the frequency of an asynchronous square wave.
// Rising edges of the synchronized input are counted over a gate window of
// CLK_HZ/GATE_DIV system clocks. At the close of each window the count is
// scaled by GATE_DIV to give Hz, saturating at 16'hFFFF.
// Optional build macro FREQ_METER_PERIOD_EN adds a rise-to-rise period
// counter. Without it, period_cycles and period_valid are tied to zero.
module freq_meter #(
    parameter int CLK_HZ   = 50_000_000,
    parameter int GATE_DIV = 10
) (
    input  logic        CLOCK_50,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        sig_in,
    output logic [15:0] freq_out,
    output logic        freq_valid,
    output logic        overflow,
    output logic [31:0] period_cycles,
    output logic        period_valid
);

    localparam int GATE_LEN = CLK_HZ / GATE_DIV;
    localparam int GW       = (GATE_LEN > 1) ? $clog2(GATE_LEN) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_LEN - 1);

    typedef enum logic {IDLE, GATE} state_t;

    state_t        state;
    logic [GW-1:0] gate_cnt;
    logic [15:0]   edge_cnt;
    logic          s1, s2, s3;
    logic          rise;
    logic [16:0]   total;
    logic [31:0]   product;

    // Synchronizer plus history FF; runs in every state so a level that is
    // already high when a window opens never looks like a fresh edge.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Closing-window arithmetic; a rise on the closing cycle is included.
    always_comb begin
        total   = {1'b0, edge_cnt} + {16'd0, rise};
        product = 32'(total) * 32'(GATE_DIV);
    end

    // Gate FSM: counts edges over the window and publishes the scaled result.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    if (enable) begin
                        state <= GATE;
                    end
                end
                GATE: begin
                    if (!enable) begin
                        // Partial window is thrown away; outputs keep old values.
                        state    <= IDLE;
                        gate_cnt <= '0;
                        edge_cnt <= '0;
                    end else if (gate_cnt == GATE_LAST) begin
                        freq_out   <= (product > 32'h0000_FFFF) ? 16'hFFFF : product[15:0];
                        overflow   <= (product > 32'h0000_FFFF);
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                    end else begin
                        gate_cnt <= gate_cnt + 1'b1;
                        if (rise && (edge_cnt != 16'hFFFF)) begin
                            edge_cnt <= edge_cnt + 16'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    logic [31:0] per_cnt;
    logic        armed;

    // Rise-to-rise period counter; the first rise after enable only arms it.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            per_cnt       <= '0;
            armed         <= 1'b0;
            period_cycles <= '0;
            period_valid  <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                armed   <= 1'b0;
                per_cnt <= '0;
            end else if (rise) begin
                if (armed) begin
                    period_cycles <= (per_cnt == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF
                                                                : per_cnt + 32'd1;
                    period_valid  <= 1'b1;
                end
                armed   <= 1'b1;
                per_cnt <= '0;
            end else if (per_cnt != 32'hFFFF_FFFF) begin
                per_cnt <= per_cnt + 32'd1;
            end
        end
    end
`else
    assign period_cycles = '0;
    assign period_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Directed testbench for freq_meter. Main instance: CLK_HZ=1000, GATE_DIV=10
// (100-cycle gate). Second instance: CLK_HZ=400000, GATE_DIV=40000 (10-cycle
// gate) so that a few edges per window already saturate the 16-bit result.
// Period checks follow FREQ_METER_PERIOD_EN.
module tb_freq_meter;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        sig_in;
    logic [15:0] freq_out;
    logic        freq_valid;
    logic        overflow;
    logic [31:0] period_cycles;
    logic        period_valid;

    logic [15:0] freq_b;
    logic        fvalid_b;
    logic        ovf_b;
    logic [31:0] per_b;
    logic        pvalid_b;

    int checks;
    int failures;

    // Background square-wave generator
    logic gen_on;
    int   gen_per;
    int   gen_phase;

    freq_meter #(.CLK_HZ(1000), .GATE_DIV(10)) dut (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .sig_in        (sig_in),
        .freq_out      (freq_out),
        .freq_valid    (freq_valid),
        .overflow      (overflow),
        .period_cycles (period_cycles),
        .period_valid  (period_valid)
    );

    freq_meter #(.CLK_HZ(400000), .GATE_DIV(40000)) dut_b (
        .CLOCK_50      (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .sig_in        (sig_in),
        .freq_out      (freq_b),
        .freq_valid    (fvalid_b),
        .overflow      (ovf_b),
        .period_cycles (per_b),
        .period_valid  (pvalid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gen_on) begin
                sig_in    = (gen_phase < gen_per / 2);
                gen_phase = (gen_phase + 1 == gen_per) ? 0 : gen_phase + 1;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_gen(input int per);
        gen_per   = per;
        gen_phase = 0;
        gen_on    = 1'b1;
    endtask

    // n = number of ticks taken until freq_valid is seen
    task automatic wait_valid(output int n, input int bound);
        n = 0;
        do begin
            tick();
            n++;
        end while (!freq_valid && n < bound);
        checks++;
        if (!freq_valid) begin
            $display("FAIL wait_valid: freq_valid not seen within %0d cycles", bound);
            failures++;
        end
    endtask

    task automatic wait_valid_b(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!fvalid_b && n < bound);
        checks++;
        if (!fvalid_b) begin
            $display("FAIL wait_valid_b: freq_valid not seen within %0d cycles", bound);
            failures++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        enable  = 1'b0;
        sig_in  = 1'b0;
        gen_on  = 1'b0;
        #23;
        checks += 5;
        if (freq_out !== 16'd0)      begin $display("FAIL reset_freq_out: got %0d expected 0", freq_out); failures++; end
        if (freq_valid !== 1'b0)     begin $display("FAIL reset_freq_valid: got %b expected 0", freq_valid); failures++; end
        if (overflow !== 1'b0)       begin $display("FAIL reset_overflow: got %b expected 0", overflow); failures++; end
        if (period_cycles !== 32'd0) begin $display("FAIL reset_period_cycles: got %0d expected 0", period_cycles); failures++; end
        if (period_valid !== 1'b0)   begin $display("FAIL reset_period_valid: got %b expected 0", period_valid); failures++; end
        reset_n = 1'b1;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_freq_10;
        int n;
        start_gen(10);
        tick();
        enable = 1'b1;
        wait_valid(n, 300);
        checks++;
        if (n != 101) begin $display("FAIL first_valid_latency: got %0d expected 101", n); failures++; end
        for (int w = 0; w < 2; w++) begin
            tick();
            checks++;
            if (freq_valid !== 1'b0) begin $display("FAIL valid_width: got %b expected 0", freq_valid); failures++; end
            wait_valid(n, 300);
            checks += 3;
            // one tick already spent checking the pulse width
            if (n != 99)              begin $display("FAIL valid_spacing: got %0d expected 99", n); failures++; end
            if (freq_out !== 16'd100) begin $display("FAIL freq_10: got %0d expected 100", freq_out); failures++; end
            if (overflow !== 1'b0)    begin $display("FAIL ovf_10: got %b expected 0", overflow); failures++; end
            $display("window period10: freq_out=%0d overflow=%b", freq_out, overflow);
        end
    endtask

    task automatic test_freq_4;
        int n;
        start_gen(4);
        wait_valid(n, 300);
        for (int w = 0; w < 2; w++) begin
            wait_valid(n, 300);
            checks += 2;
            if (freq_out !== 16'd250) begin $display("FAIL freq_4: got %0d expected 250", freq_out); failures++; end
            if (overflow !== 1'b0)    begin $display("FAIL ovf_4: got %b expected 0", overflow); failures++; end
            $display("window period4: freq_out=%0d overflow=%b", freq_out, overflow);
        end
    endtask

    task automatic test_constant;
        int n;
        gen_on = 1'b0;
        sig_in = 1'b0;
        wait_valid(n, 300);
        wait_valid(n, 300);
        checks++;
        if (freq_out !== 16'd0) begin $display("FAIL const_low: got %0d expected 0", freq_out); failures++; end
        $display("window const low: freq_out=%0d", freq_out);
        sig_in = 1'b1;
        wait_valid(n, 300);
        wait_valid(n, 300);
        checks++;
        if (freq_out !== 16'd0) begin $display("FAIL const_high: got %0d expected 0", freq_out); failures++; end
        $display("window const high: freq_out=%0d", freq_out);
    endtask

    // Nine ordinary edges plus one whose rise lands on the closing cycle.
    // A level set at tick i produces a rise during gate cycle i+2.
    task automatic test_closing_edge;
        int n;
        gen_on = 1'b0;
        sig_in = 1'b0;
        wait_valid(n, 300);
        wait_valid(n, 300);
        for (int i = 0; i < 100; i++) begin
            if (i < 90)       sig_in = ((i % 10) < 5);
            else if (i < 97)  sig_in = 1'b0;
            else              sig_in = 1'b1;
            tick();
        end
        checks += 2;
        if (freq_valid !== 1'b1)  begin $display("FAIL closing_valid: got %b expected 1", freq_valid); failures++; end
        if (freq_out !== 16'd100) begin $display("FAIL closing_edge: got %0d expected 100", freq_out); failures++; end
        $display("window closing edge: freq_out=%0d", freq_out);
        wait_valid(n, 300);
        checks += 2;
        if (n != 100)           begin $display("FAIL closing_next_spacing: got %0d expected 100", n); failures++; end
        if (freq_out !== 16'd0) begin $display("FAIL closing_next_window: got %0d expected 0", freq_out); failures++; end
        $display("window after closing edge: freq_out=%0d", freq_out);
    endtask

    task automatic test_enable_drop;
        int n;
        logic seen;
        start_gen(10);
        wait_valid(n, 300);
        wait_valid(n, 300);
        checks++;
        if (freq_out !== 16'd100) begin $display("FAIL drop_pre: got %0d expected 100", freq_out); failures++; end
        for (int i = 0; i < 50; i++) tick();
        enable = 1'b0;
        seen   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (freq_valid) seen = 1'b1;
        end
        checks += 2;
        if (seen !== 1'b0)        begin $display("FAIL drop_no_valid: got %b expected 0", seen); failures++; end
        if (freq_out !== 16'd100) begin $display("FAIL drop_hold: got %0d expected 100", freq_out); failures++; end
        enable = 1'b1;
        wait_valid(n, 300);
        checks += 2;
        if (n != 101)             begin $display("FAIL reenable_latency: got %0d expected 101", n); failures++; end
        if (freq_out !== 16'd100) begin $display("FAIL reenable_freq: got %0d expected 100", freq_out); failures++; end
        $display("enable drop/re-enable: latency=%0d freq_out=%0d", n, freq_out);
    endtask

    task automatic test_overflow;
        start_gen(4);
        for (int w = 0; w < 3; w++) wait_valid_b(50);
        checks += 3;
        if (freq_b !== 16'hFFFF) begin $display("FAIL ovf_sat_freq: got %0h expected ffff", freq_b); failures++; end
        if (ovf_b !== 1'b1)      begin $display("FAIL ovf_sat_flag: got %b expected 1", ovf_b); failures++; end
        if (overflow !== 1'b0)   begin $display("FAIL ovf_main_flag: got %b expected 0", overflow); failures++; end
        $display("saturating window: freq_out=%0h overflow=%b", freq_b, ovf_b);
        gen_on = 1'b0;
        sig_in = 1'b0;
        for (int w = 0; w < 3; w++) wait_valid_b(50);
        checks += 2;
        if (freq_b !== 16'd0) begin $display("FAIL ovf_clear_freq: got %0d expected 0", freq_b); failures++; end
        if (ovf_b !== 1'b0)   begin $display("FAIL ovf_clear_flag: got %b expected 0", ovf_b); failures++; end
        $display("unsaturated window: freq_out=%0d overflow=%b", freq_b, ovf_b);
    endtask

    task automatic test_period;
        int n;
        start_gen(10);
`ifdef FREQ_METER_PERIOD_EN
        enable = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_valid && n < 50);
        checks += 2;
        if (n < 11 || !period_valid) begin $display("FAIL period_first: got %0d cycles expected 11..20", n); failures++; end
        if (period_cycles !== 32'd10) begin $display("FAIL period_first_value: got %0d expected 10", period_cycles); failures++; end
        tick();
        checks++;
        if (period_valid !== 1'b0) begin $display("FAIL period_width: got %b expected 0", period_valid); failures++; end
        n = 0;
        do begin
            tick();
            n++;
        end while (!period_valid && n < 50);
        checks += 2;
        if (n != 9)                   begin $display("FAIL period_spacing: got %0d expected 9", n); failures++; end
        if (period_cycles !== 32'd10) begin $display("FAIL period_value: got %0d expected 10", period_cycles); failures++; end
        $display("period: period_cycles=%0d", period_cycles);
`else
        begin
            logic bad_valid;
            logic bad_cycles;
            bad_valid  = 1'b0;
            bad_cycles = 1'b0;
            for (int i = 0; i < 300; i++) begin
                tick();
                if (period_valid !== 1'b0)   bad_valid = 1'b1;
                if (period_cycles !== 32'd0) bad_cycles = 1'b1;
            end
            checks += 2;
            if (bad_valid)  begin $display("FAIL period_tied_valid: got %b expected 0", period_valid); failures++; end
            if (bad_cycles) begin $display("FAIL period_tied_cycles: got %0d expected 0", period_cycles); failures++; end
            $display("period disabled: period_cycles=%0d period_valid=%b", period_cycles, period_valid);
        end
`endif
        wait_valid(n, 300);
    endtask

    task automatic test_reset_mid;
        int n;
        start_gen(10);
        wait_valid(n, 300);
        wait_valid(n, 300);
        checks++;
        if (freq_out !== 16'd100) begin $display("FAIL midreset_pre: got %0d expected 100", freq_out); failures++; end
        for (int i = 0; i < 30; i++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks += 6;
        if (freq_out !== 16'd0)      begin $display("FAIL midreset_freq: got %0d expected 0", freq_out); failures++; end
        if (freq_valid !== 1'b0)     begin $display("FAIL midreset_valid: got %b expected 0", freq_valid); failures++; end
        if (overflow !== 1'b0)       begin $display("FAIL midreset_ovf: got %b expected 0", overflow); failures++; end
        if (period_cycles !== 32'd0) begin $display("FAIL midreset_period: got %0d expected 0", period_cycles); failures++; end
        if (period_valid !== 1'b0)   begin $display("FAIL midreset_pvalid: got %b expected 0", period_valid); failures++; end
        if (freq_b !== 16'd0)        begin $display("FAIL midreset_freq_b: got %0d expected 0", freq_b); failures++; end
        $display("mid-window reset: freq_out=%0d", freq_out);
        #3;
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        gen_per   = 10;
        gen_phase = 0;
        test_reset();
        test_freq_10();
        test_freq_4();
        test_constant();
        test_closing_edge();
        test_enable_drop();
        test_overflow();
        test_period();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
